// File: rtl/access_controller.sv
// Four-digit code entry, password compare, grant/fail/lockout sequencing.
// Timed lockout after MAX_TRIES consecutive failures is built only when ACCESS_LOCKOUT_EN is defined.
module access_controller #(
    parameter logic [15:0] PASSWORD    = 16'h5440,
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCK_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_pulse,
    input  logic       logout_pulse,
    input  logic [3:0] digit_in,
    output logic       grant,
    output logic       fail,
    output logic       locked,
    output logic [2:0] digit_cnt,
    output logic [1:0] fail_cnt
);

    localparam logic [2:0] ST_ENTER   = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_GRANTED = 3'd2;
    localparam logic [2:0] ST_DENIED  = 3'd3;
`ifdef ACCESS_LOCKOUT_EN
    localparam logic [2:0]  ST_LOCKOUT = 3'd4;
    localparam logic [1:0]  TRIES_LIM  = 2'(MAX_TRIES);
    localparam logic [31:0] LOCK_LAST  = 32'(LOCK_CYCLES - 1);
`endif

    logic [2:0]  state_r, state_s;
    logic [15:0] code_r, code_s;
    logic [2:0]  digit_cnt_r, digit_cnt_s;
    logic [1:0]  fail_cnt_r, fail_cnt_s;
    logic        grant_r;
    logic        fail_r;
`ifdef ACCESS_LOCKOUT_EN
    logic [31:0] lock_cnt_r, lock_cnt_s;
    logic        locked_r;
`endif

    // Next-state, code shift register and counter updates.
    always_comb begin
        state_s     = state_r;
        code_s      = code_r;
        digit_cnt_s = digit_cnt_r;
        fail_cnt_s  = fail_cnt_r;
`ifdef ACCESS_LOCKOUT_EN
        lock_cnt_s  = lock_cnt_r;
`endif
        case (state_r)
            ST_ENTER: begin
                if (load_pulse) begin
                    code_s      = {code_r[11:0], digit_in};
                    digit_cnt_s = digit_cnt_r + 3'd1;
                    if (digit_cnt_r == 3'd3) begin
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_ENTER;
                    end
                end else begin
                    state_s = ST_ENTER;
                end
            end
            ST_CHECK: begin
                digit_cnt_s = 3'd0;
                if (code_r == PASSWORD) begin
                    state_s    = ST_GRANTED;
                    fail_cnt_s = 2'd0;
                end else begin
                    state_s = ST_DENIED;
                    // Saturates so the count never wraps back to zero
                    if (fail_cnt_r == 2'd3) begin
                        fail_cnt_s = 2'd3;
                    end else begin
                        fail_cnt_s = fail_cnt_r + 2'd1;
                    end
                end
            end
            ST_GRANTED: begin
                if (logout_pulse) begin
                    state_s = ST_ENTER;
                    code_s  = 16'h0000;
                end else begin
                    state_s = ST_GRANTED;
                end
            end
            ST_DENIED: begin
                code_s = 16'h0000;
`ifdef ACCESS_LOCKOUT_EN
                if (fail_cnt_r == TRIES_LIM) begin
                    state_s = ST_LOCKOUT;
                end else begin
                    state_s = ST_ENTER;
                end
`else
                state_s = ST_ENTER;
`endif
            end
`ifdef ACCESS_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (lock_cnt_r == LOCK_LAST) begin
                    state_s    = ST_ENTER;
                    lock_cnt_s = 32'd0;
                    fail_cnt_s = 2'd0;
                end else begin
                    state_s    = ST_LOCKOUT;
                    lock_cnt_s = lock_cnt_r + 32'd1;
                end
            end
`endif
            default: begin
                state_s     = ST_ENTER;
                code_s      = 16'h0000;
                digit_cnt_s = 3'd0;
            end
        endcase
    end

    // State and counter registers; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_ENTER;
            code_r      <= 16'h0000;
            digit_cnt_r <= 3'd0;
            fail_cnt_r  <= 2'd0;
            grant_r     <= 1'b0;
            fail_r      <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
            lock_cnt_r  <= 32'd0;
            locked_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            code_r      <= code_s;
            digit_cnt_r <= digit_cnt_s;
            fail_cnt_r  <= fail_cnt_s;
            grant_r     <= (state_s == ST_GRANTED);
            fail_r      <= (state_s == ST_DENIED);
`ifdef ACCESS_LOCKOUT_EN
            lock_cnt_r  <= lock_cnt_s;
            locked_r    <= (state_s == ST_LOCKOUT);
`endif
        end
    end

    assign grant     = grant_r;
    assign fail      = fail_r;
    assign digit_cnt = digit_cnt_r;
    assign fail_cnt  = fail_cnt_r;
`ifdef ACCESS_LOCKOUT_EN
    assign locked    = locked_r;
`else
    assign locked    = 1'b0;
`endif

endmodule

// File: tb/tb_access_controller.sv
// Scoreboard bench for access_controller: stimulus queues expected outputs, a negedge monitor compares.
module tb_access_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_pulse = 1'b0;
    logic       logout_pulse = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       grant, fail, locked;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t cur;
    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;
    logic [7:0] act;

    access_controller #(
        .PASSWORD(16'h5440),
        .MAX_TRIES(3),
        .LOCK_CYCLES(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_pulse(load_pulse),
        .logout_pulse(logout_pulse),
        .digit_in(digit_in),
        .grant(grant),
        .fail(fail),
        .locked(locked),
        .digit_cnt(digit_cnt),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due at this cycle and compare.
    always @(negedge clk) begin
        act = {grant, fail, locked, digit_cnt, fail_cnt};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            checks = checks + 1;
            if (cur.cyc != cyc || act !== cur.exp) begin
                errors = errors + 1;
                $display("FAIL %s: got g,f,l,dc,fc=%b expected %b (cycle %0d, due %0d)",
                         cur.name, act, cur.exp, cyc, cur.cyc);
            end
        end
    end

    // Queue the expected outputs after the next edge, then apply one cycle of inputs.
    task automatic st(input logic ld, input logic lo, input logic [3:0] d, input string nm,
                      input logic g, input logic f, input logic l,
                      input logic [2:0] dc, input logic [1:0] fc);
        sb_entry_t e;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.exp  = {g, f, l, dc, fc};
        sb.push_back(e);
        load_pulse   = ld;
        logout_pulse = lo;
        digit_in     = d;
        @(posedge clk);
        #1;
        load_pulse   = 1'b0;
        logout_pulse = 1'b0;
    endtask

    // Enters a wrong code 1,2,3,4 and checks the resulting fail pulse.
    task automatic wrong_code(input logic [1:0] fc_before, input logic [1:0] fc_after);
        st(1'b1, 1'b0, 4'd1, "wrong_d1", 1'b0, 1'b0, 1'b0, 3'd1, fc_before);
        st(1'b1, 1'b0, 4'd2, "wrong_d2", 1'b0, 1'b0, 1'b0, 3'd2, fc_before);
        st(1'b1, 1'b0, 4'd3, "wrong_d3", 1'b0, 1'b0, 1'b0, 3'd3, fc_before);
        st(1'b1, 1'b0, 4'd4, "wrong_d4", 1'b0, 1'b0, 1'b0, 3'd4, fc_before);
        st(1'b0, 1'b0, 4'd0, "wrong_fail", 1'b0, 1'b1, 1'b0, 3'd0, fc_after);
    endtask

    // Enters 5,4,4,0 and checks grant two edges after the last digit.
    task automatic good_code(input logic [1:0] fc_before);
        st(1'b1, 1'b0, 4'd5, "good_d1", 1'b0, 1'b0, 1'b0, 3'd1, fc_before);
        st(1'b1, 1'b0, 4'd4, "good_d2", 1'b0, 1'b0, 1'b0, 3'd2, fc_before);
        st(1'b1, 1'b0, 4'd4, "good_d3", 1'b0, 1'b0, 1'b0, 3'd3, fc_before);
        st(1'b1, 1'b0, 4'd0, "good_d4", 1'b0, 1'b0, 1'b0, 3'd4, fc_before);
        st(1'b0, 1'b0, 4'd0, "good_grant", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
    endtask

    initial begin
        // Reset held with random pulses
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               "reset", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        end
        rst = 1'b1;

        // Correct code, hold, logout
        good_code(2'd0);
        st(1'b0, 1'b0, 4'd0, "grant_hold", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        st(1'b0, 1'b1, 4'd0, "logout", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

        // Three wrong codes
        wrong_code(2'd0, 2'd1);
        st(1'b0, 1'b0, 4'd0, "fail_one_cycle", 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);
        wrong_code(2'd1, 2'd2);
        st(1'b0, 1'b0, 4'd0, "fail2_end", 1'b0, 1'b0, 1'b0, 3'd0, 2'd2);
        wrong_code(2'd2, 2'd3);
`ifdef ACCESS_LOCKOUT_EN
        st(1'b0, 1'b0, 4'd0, "lock_enter", 1'b0, 1'b0, 1'b1, 3'd0, 2'd3);
        for (int i = 0; i < 4; i++) begin
            st(1'b1, 1'(i % 2), 4'd5, "lock_hold", 1'b0, 1'b0, 1'b1, 3'd0, 2'd3);
        end
        st(1'b1, 1'b0, 4'd5, "lock_exit", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        good_code(2'd0);
`else
        st(1'b0, 1'b0, 4'd0, "nolock_enter", 1'b0, 1'b0, 1'b0, 3'd0, 2'd3);
        wrong_code(2'd3, 2'd3);
        st(1'b0, 1'b0, 4'd0, "nolock_sat", 1'b0, 1'b0, 1'b0, 3'd0, 2'd3);
        good_code(2'd3);
`endif

        // Ignored load in GRANTED, simultaneous load+logout ends session
        st(1'b1, 1'b0, 4'd7, "grant_ignore_load", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        st(1'b1, 1'b1, 4'd7, "grant_both_pulses", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        st(1'b0, 1'b0, 4'd0, "after_logout", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

        // Reset mid-entry then a fresh grant
        st(1'b1, 1'b0, 4'd1, "mid_d1", 1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        st(1'b1, 1'b0, 4'd2, "mid_d2", 1'b0, 1'b0, 1'b0, 3'd2, 2'd0);
        rst = 1'b0;
        st(1'b1, 1'b0, 4'd3, "mid_reset", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        rst = 1'b1;
        good_code(2'd0);
        st(1'b0, 1'b1, 4'd0, "final_logout", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors = errors + sb.size();
            $display("FAIL scoreboard_drain: %0d expectations never compared, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
